// File: rtl/coin_conditioner.sv
// rtl/coin_conditioner.sv - two-channel coin sensor synchronizer, debouncer, jam detector and pulse arbiter
// Each channel debounces its sensor independently; a shared output stage turns accepted coins into single pulses.

module coin_channel #(
    parameter int DEBOUNCE  = 4,
    parameter int JAM_LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic accept,
    output logic jam
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        HELD    = 3'd2,
        RELEASE = 3'd3,
        JAM     = 3'd4
    } state_t;

    localparam logic [7:0] DEB_MAX  = 8'(DEBOUNCE);
    localparam logic [7:0] JAM_MAX  = 8'(JAM_LIMIT);

    state_t     state, state_nxt;
    logic [7:0] deb_cnt, deb_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [7:0] deb_inc, hold_inc;

    assign deb_inc  = deb_cnt + 8'd1;
    assign hold_inc = hold_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            deb_cnt  <= 8'd0;
            hold_cnt <= 8'd0;
            jam      <= 1'b0;
        end else begin
            state    <= state_nxt;
            deb_cnt  <= deb_nxt;
            hold_cnt <= hold_nxt;
            jam      <= (state_nxt == JAM);
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS;
                    deb_nxt   = 8'd1;
                end
            end
            PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                    deb_nxt   = 8'd0;
                end else if (deb_inc == DEB_MAX) begin
                    state_nxt = HELD;
                    deb_nxt   = 8'd0;
                    hold_nxt  = 8'd0;
                end else begin
                    deb_nxt   = deb_inc;
                end
            end
            HELD: begin
                hold_nxt = hold_inc;
                if (hold_inc == JAM_MAX) begin
                    state_nxt = JAM;
                    deb_nxt   = 8'd0;
                end else if (!s) begin
                    state_nxt = RELEASE;
                    deb_nxt   = 8'd1;
                end
            end
            RELEASE: begin
                // A bounce back to high resumes the same coin; hold time is not reset.
                if (s) begin
                    state_nxt = HELD;
                    deb_nxt   = 8'd0;
                end else if (deb_inc == DEB_MAX) begin
                    state_nxt = IDLE;
                    deb_nxt   = 8'd0;
                    hold_nxt  = 8'd0;
                end else begin
                    deb_nxt   = deb_inc;
                end
            end
            JAM: begin
                if (s) begin
                    deb_nxt   = 8'd0;
                end else if (deb_inc == DEB_MAX) begin
                    state_nxt = IDLE;
                    deb_nxt   = 8'd0;
                    hold_nxt  = 8'd0;
                end else begin
                    deb_nxt   = deb_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = 8'd0;
                hold_nxt  = 8'd0;
            end
        endcase
    end

    always_comb begin
        accept = 1'b0;
        if (state == PRESS && s && deb_inc == DEB_MAX)
            accept = 1'b1;
    end
endmodule

module coin_conditioner #(
    parameter int DEBOUNCE  = 4,
    parameter int JAM_LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_x,
    input  logic raw_y,
    input  logic en,
    output logic inx,
    output logic iny,
    output logic jam_x,
    output logic jam_y,
    output logic ovf
);
    logic [1:0] sync_x, sync_y;
    logic       accept_x, accept_y;
    logic       pend_x, pend_y;
    logic       consume_x, consume_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_x <= 2'b00;
            sync_y <= 2'b00;
        end else begin
            sync_x <= {sync_x[0], raw_x};
            sync_y <= {sync_y[0], raw_y};
        end
    end

    coin_channel #(.DEBOUNCE(DEBOUNCE), .JAM_LIMIT(JAM_LIMIT)) u_chan_x (
        .clk    (clk),
        .rst    (rst),
        .s      (sync_x[1]),
        .accept (accept_x),
        .jam    (jam_x)
    );

    coin_channel #(.DEBOUNCE(DEBOUNCE), .JAM_LIMIT(JAM_LIMIT)) u_chan_y (
        .clk    (clk),
        .rst    (rst),
        .s      (sync_y[1]),
        .accept (accept_y),
        .jam    (jam_y)
    );

    // Only flags already registered are consumed, so a coin never pulses on its own acceptance edge.
    assign consume_x = en & pend_x;
    assign consume_y = en & ~pend_x & pend_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_x <= 1'b0;
            pend_y <= 1'b0;
            inx    <= 1'b0;
            iny    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            pend_x <= accept_x | (pend_x & ~consume_x);
            pend_y <= accept_y | (pend_y & ~consume_y);
            inx    <= consume_x;
            iny    <= consume_y;
            ovf    <= ovf | (accept_x & pend_x) | (accept_y & pend_y);
        end
    end
endmodule

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable sampled cycles needed to accept a press or a release; legal range 2..255.
REQ-002 Parameter JAM_LIMIT, default 64: consecutive cycles a coin may stay in HELD before it is declared jammed; legal range DEBOUNCE+1..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low; the block is in reset while rst=0.
REQ-005 raw_x  input  1  asynchronous 5-unit coin sensor level, high while a coin is present.
REQ-006 raw_y  input  1  asynchronous 10-unit coin sensor level, high while a coin is present.
REQ-007 en  input  1  downstream vendor ready; pulses are issued only while en=1.
REQ-008 inx  output  1  registered one-cycle pulse, one per accepted 5-unit coin; drives the vendor FSM inx.
REQ-009 iny  output  1  registered one-cycle pulse, one per accepted 10-unit coin; drives the vendor FSM iny.
REQ-010 jam_x  output  1  registered; high while channel x is in JAM.
REQ-011 jam_y  output  1  registered; high while channel y is in JAM.
REQ-012 ovf  output  1  registered sticky flag: a coin was accepted while its channel pending flag was already set.

Function
REQ-013 Each raw input shall pass through a 2-flop synchronizer; s_x and s_y denote the synchronized levels, and no other logic shall sample raw_x or raw_y.
REQ-014 Each channel shall run an independent FSM with states IDLE, PRESS, HELD, RELEASE and JAM, plus an 8-bit debounce counter and an 8-bit hold counter.
REQ-015 IDLE: s=1 goes to PRESS with debounce count=1; otherwise the FSM stays in IDLE.
REQ-016 PRESS: s=0 returns to IDLE with no coin; s=1 increments the count; on the cycle the count reaches DEBOUNCE the FSM goes to HELD, sets the channel pending flag, and sets hold count=0.
REQ-017 HELD: the hold counter increments every cycle; when it reaches JAM_LIMIT the FSM goes to JAM; otherwise s=0 goes to RELEASE with debounce count=1.
REQ-018 RELEASE: s=1 returns to HELD with no new coin and the hold counter keeps its value; DEBOUNCE consecutive s=0 cycles return to IDLE.
REQ-019 JAM: the jam flag is high and no pending flag is set; DEBOUNCE consecutive s=0 cycles return to IDLE and clear the jam flag; any s=1 restarts that count.
REQ-020 A jam raised after acceptance shall not cancel that coin's pending flag.
REQ-021 Output stage, each cycle with en=1: if pend_x is set, inx=1 and pend_x is cleared; else if pend_y is set, iny=1 and pend_y is cleared; otherwise inx=iny=0.
REQ-022 inx and iny shall never both be high in the same cycle.
REQ-023 Simultaneous acceptance on both channels shall give inx in the first cycle and iny in the next cycle.
REQ-024 While en=0, inx=iny=0 and both pending flags shall hold their values.
REQ-025 If a channel accepts a coin while its pending flag is already 1, the pending flag shall stay 1 (the new coin is lost) and ovf shall be set to 1 until reset.
REQ-026 Latency with en=1 and no contention: raw first sampled high at edge 1 gives a pulse high from edge DEBOUNCE+3 to edge DEBOUNCE+4 (edges 7 to 8 for DEBOUNCE=4).
REQ-027 A pend set and cleared on the same edge cannot occur; a flag set at edge n shall be consumed no earlier than edge n+1.

Reset
REQ-028 While rst=0, synchronizers=0, both FSMs are in IDLE, counters=0, pend_x=pend_y=0, and inx=iny=jam_x=jam_y=ovf=0, all asynchronously.
REQ-029 Deassertion of rst mid-press or mid-jam shall leave the block in IDLE, and a sensor still high shall be re-debounced from scratch.

Verification
REQ-030 raw_x high for 10 cycles with en=1 and DEBOUNCE=4 shall give a single inx pulse, high from edge 7 to edge 8; iny stays 0.
REQ-031 raw_y glitch high for 3 cycles then low shall give no iny pulse, and the channel y FSM shall return to IDLE.
REQ-032 raw_x and raw_y rising on the same edge and held shall give inx at edge 7 and iny at edge 8.
REQ-033 en=0 while two x coins are accepted, then en=1, shall give exactly one inx pulse, and ovf shall read 1.
REQ-034 raw_y held for 80 cycles with JAM_LIMIT=64 shall give one iny pulse, then jam_y=1; after raw_y falls, jam_y shall return to 0 after 4+2 cycles.
REQ-035 rst pulsed low for 1 cycle during PRESS with raw_x still high shall give all outputs 0 at once and an inx pulse 7 edges after release.
